core_run_controller: RTL and testbench
======================================

Name: core_run_controller

Overview:
- Responder side of the startN / processor_ready / processDone handshake that the simulation top and board top drive.
- Accepts an active-low start request and issues a one-cycle start pulse to all CORE_COUNT cores.
- Collects each core's done indication and raises processDone once every core has finished.
- Reports the run length in clock cycles and aborts a hung run by timeout.

Parameters:
- CORE_COUNT, 1, number of cores started and monitored (1..16).
- CNT_WIDTH, 32, width of the cycle counter.
- TIMEOUT_CYCLES, 1000000, RUN cycles before a forced abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rstN  input  1  asynchronous active-low reset.
- startN  input  1  active-low start request, synchronous to clk.
- core_done  input  CORE_COUNT  per-core done; may be a pulse or a level.
- core_start  output  CORE_COUNT  per-core start pulse, all bits identical.
- processor_ready  output  1  high when a new start is accepted.
- processDone  output  1  high when the last run has completed.
- cycle_count  output  CNT_WIDTH  RUN-cycle count of the current or last run.
- timeout  output  1  last run ended by timeout.

Behaviour:
- One clock. Reset is asynchronous and active-low: ports clk and rstN.
- All outputs are registered.
- Reset values: state IDLE, core_start 0, processor_ready 1, processDone 0, cycle_count 0, timeout 0, done_seen 0, startN_q 1.
- Reset asserted mid-run forces the reset values immediately; no start pulse may leak out.
- Start detect: a start is taken at an edge where startN == 0, startN_q == 1 and state is IDLE or DONE. startN_q is startN registered.
  - Holding startN low re-triggers nothing; startN must return high first.
  - startN falling during START or RUN is ignored.
- IDLE -> START on a start.
  - At that edge: processor_ready <= 0, processDone <= 0, timeout <= 0, cycle_count <= 0, done_seen <= 0, core_start <= all ones.
- START -> RUN unconditionally after one cycle; core_start <= 0.
  - core_start is high for exactly one clk cycle.
  - core_done bits seen during START are captured into done_seen.
- RUN:
  - Each cycle: done_seen <= done_seen | core_done.
  - cycle_count increments by 1 and saturates at all ones.
- RUN -> DONE at the first edge where (done_seen | core_done) is all ones.
  - At that edge: processDone <= 1, processor_ready <= 1.
  - cycle_count keeps its value, which includes that final cycle.
- RUN -> DONE on timeout: TIMEOUT_CYCLES != 0 and cycle_count == TIMEOUT_CYCLES - 1 at an edge without all-done.
  - At that edge: timeout <= 1, processDone <= 1, processor_ready <= 1.
  - If all-done and timeout coincide, all-done wins and timeout stays 0.
- DONE: processDone, cycle_count and timeout hold.
  - A new start behaves exactly as from IDLE: processDone drops at the same edge that raises core_start.
- Latency:
  - Start-accepting edge k: core_start high in cycle k..k+1, RUN from edge k+1.
  - A core_done pulse high before edge m (m ≥ k+1) that completes the set gives processDone high after edge m, with cycle_count = m - k.
- A core_done pulse arriving while in IDLE or DONE is ignored.

Test Plan:
- Basic run, CORE_COUNT=1: reset; startN low 1 cycle at edge 2; core_done pulses 1 cycle before edge 12.
  - core_start high only between edges 2 and 3; processor_ready low edges 2..12.
  - processDone=1 after edge 12; cycle_count=10; timeout=0.
- Multicore, CORE_COUNT=4: done pulses arrive at RUN cycles 3, 7, 5, 9, each 1 cycle long.
  - processDone rises only after the 9th RUN cycle; cycle_count=9.
  - Repeat with all four dones at cycle 6: cycle_count=6.
- Start hygiene:
  - startN held low 20 cycles gives exactly one core_start pulse.
  - startN toggled during RUN has no effect.
  - After processDone, a second start clears processDone and cycle_count and runs again; the done pulse 4 cycles into RUN gives cycle_count=4.
- Timeout with TIMEOUT_CYCLES=50 and no core_done: processDone=1 and timeout=1 after 50 RUN cycles, cycle_count=50.
  - Done arriving on exactly the 50th RUN cycle gives timeout=0.
- Early done: core_done held high from START onward → processDone after first RUN edge, cycle_count=1.
- Reset mid-RUN (cycle 5) → all outputs return to reset values immediately; next start behaves as first run.

Source files
------------

// File: rtl/core_run_controller.sv
// Start/done handshake responder: pulses core_start to every core, waits for all
// cores to report done, measures the run length and aborts hung runs by timeout.
module core_run_controller #(
    parameter int          CORE_COUNT     = 1,
    parameter int          CNT_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  startN,
    input  logic [CORE_COUNT-1:0] core_done,
    output logic [CORE_COUNT-1:0] core_start,
    output logic                  processor_ready,
    output logic                  processDone,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic                  timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                state_q,      state_d;
    logic [CORE_COUNT-1:0] core_start_q, core_start_d;
    logic [CORE_COUNT-1:0] done_seen_q,  done_seen_d;
    logic                  ready_q,      ready_d;
    logic                  proc_done_q,  proc_done_d;
    logic                  timeout_q,    timeout_d;
    logic                  start_n_q,    start_n_d;
    logic [CNT_WIDTH-1:0]  count_q,      count_d;

    logic                  start_ok;
    logic                  all_done;
    logic                  timeout_hit;
    logic [CNT_WIDTH-1:0]  count_inc;

    always_comb begin
        state_d      = state_q;
        core_start_d = core_start_q;
        done_seen_d  = done_seen_q;
        ready_d      = ready_q;
        proc_done_d  = proc_done_q;
        timeout_d    = timeout_q;
        count_d      = count_q;
        start_n_d    = startN;

        start_ok    = !startN && start_n_q && (state_q == IDLE || state_q == DONE);
        all_done    = &(done_seen_q | core_done);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (count_q == TO_LAST);
        count_inc   = (&count_q) ? count_q : count_q + CNT_WIDTH'(1);

        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_d      = START;
                    core_start_d = '1;
                    done_seen_d  = '0;
                    ready_d      = 1'b0;
                    proc_done_d  = 1'b0;
                    timeout_d    = 1'b0;
                    count_d      = '0;
                end
            end
            // START is counted as the first run cycle, so a done already present
            // there completes the run at the very next edge with a count of 1.
            START, RUN: begin
                core_start_d = '0;
                done_seen_d  = done_seen_q | core_done;
                count_d      = count_inc;
                if (all_done) begin
                    state_d     = DONE;
                    proc_done_d = 1'b1;
                    ready_d     = 1'b1;
                end else if (timeout_hit) begin
                    state_d     = DONE;
                    proc_done_d = 1'b1;
                    ready_d     = 1'b1;
                    timeout_d   = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= IDLE;
            core_start_q <= '0;
            done_seen_q  <= '0;
            ready_q      <= 1'b1;
            proc_done_q  <= 1'b0;
            timeout_q    <= 1'b0;
            start_n_q    <= 1'b1;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            core_start_q <= core_start_d;
            done_seen_q  <= done_seen_d;
            ready_q      <= ready_d;
            proc_done_q  <= proc_done_d;
            timeout_q    <= timeout_d;
            start_n_q    <= start_n_d;
            count_q      <= count_d;
        end
    end

    assign core_start      = core_start_q;
    assign processor_ready = ready_q;
    assign processDone     = proc_done_q;
    assign cycle_count     = count_q;
    assign timeout         = timeout_q;

endmodule

// File: tb/tb_core_run_controller.sv
// Directed bench: three controller instances (1 core / timeout 50, 4 cores,
// 4-bit saturating counter with timeout disabled) sharing clock, reset and start.
module tb_core_run_controller;

    logic        clk;
    logic        rstN;
    logic        startN;
    logic        done1;
    logic [3:0]  done4;
    logic        done_s;

    logic        cs1, rdy1, pd1, to1;
    logic [31:0] cc1;
    logic [3:0]  cs4;
    logic        rdy4, pd4, to4;
    logic [31:0] cc4;
    logic        css, rdys, pds, tos;
    logic [3:0]  ccs;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    core_run_controller #(.CORE_COUNT(1), .CNT_WIDTH(32), .TIMEOUT_CYCLES(50)) dut1 (
        .clk(clk), .rstN(rstN), .startN(startN), .core_done(done1),
        .core_start(cs1), .processor_ready(rdy1), .processDone(pd1),
        .cycle_count(cc1), .timeout(to1)
    );

    core_run_controller #(.CORE_COUNT(4)) dut4 (
        .clk(clk), .rstN(rstN), .startN(startN), .core_done(done4),
        .core_start(cs4), .processor_ready(rdy4), .processDone(pd4),
        .cycle_count(cc4), .timeout(to4)
    );

    core_run_controller #(.CORE_COUNT(1), .CNT_WIDTH(4), .TIMEOUT_CYCLES(0)) dut_s (
        .clk(clk), .rstN(rstN), .startN(startN), .core_done(done_s),
        .core_start(css), .processor_ready(rdys), .processDone(pds),
        .cycle_count(ccs), .timeout(tos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstN   = 1'b0;
        startN = 1'b1;
        done1  = 1'b0;
        done4  = 4'h0;
        done_s = 1'b1;
        tick();
        tick();
        check("rst_ready",   rdy1, 1);
        check("rst_done",    pd1,  0);
        check("rst_count",   cc1,  0);
        check("rst_timeout", to1,  0);
        check("rst_start",   cs1,  0);
        check("rst_start4",  cs4,  0);
        rstN = 1'b1;
        tick();

        // Phase 1: basic run (dut1), staggered multicore dones (dut4), early done (dut_s)
        startN = 1'b0;
        tick();                                   // edge k
        check("k_start1", cs1, 1);
        check("k_start4", cs4, 4'hf);
        check("k_ready1", rdy1, 0);
        check("k_count1", cc1, 0);
        startN = 1'b1;
        tick();                                   // edge k+1
        check("k1_start1", cs1, 0);
        check("k1_count1", cc1, 1);
        check("early_done", pds, 1);
        check("early_count", ccs, 1);
        check("early_ready", rdys, 1);
        check("early_timeout", tos, 0);
        for (int e = 2; e <= 10; e++) begin
            done4  = {e == 9, e == 5, e == 7, e == 3};
            done1  = (e == 10);
            startN = (e == 4 || e == 5) ? 1'b0 : 1'b1;
            tick();                               // edge k+e
            done4 = 4'h0;
            done1 = 1'b0;
            if (e == 8) check("mc_not_yet", pd4, 0);
            if (e == 9) begin
                check("mc_done", pd4, 1);
                check("mc_count", cc4, 9);
                check("mc_timeout", to4, 0);
                check("basic_ready_low", rdy1, 0);
                check("basic_not_done", pd1, 0);
            end
            if (e == 10) begin
                check("basic_done", pd1, 1);
                check("basic_ready", rdy1, 1);
                check("basic_count", cc1, 10);
                check("basic_timeout", to1, 0);
                check("mc_hold_count", cc4, 9);
                check("basic_no_restart", cs1, 0);
            end
        end

        // Phase 2: second start held low 20 cycles; done 4 cycles in; all four dones at cycle 6
        startN = 1'b0;
        tick();                                   // edge k2
        check("k2_start1", cs1, 1);
        check("k2_done_cleared", pd1, 0);
        check("k2_count_cleared", cc1, 0);
        check("k2_done4_cleared", pd4, 0);
        pulses = 1;
        for (int e = 1; e <= 19; e++) begin
            done1 = (e == 4);
            done4 = (e == 6) ? 4'hf : 4'h0;
            tick();
            done1 = 1'b0;
            done4 = 4'h0;
            if (cs1) pulses++;
            if (e == 4) begin
                check("rerun_done", pd1, 1);
                check("rerun_count", cc1, 4);
            end
            if (e == 6) begin
                check("mc_same_done", pd4, 1);
                check("mc_same_count", cc4, 6);
            end
        end
        check("held_low_pulses", pulses, 1);
        check("rerun_hold_count", cc1, 4);
        startN = 1'b1;

        // Phase 3: timeout on dut1, saturation with timeout disabled on dut_s
        done_s = 1'b0;
        tick();
        startN = 1'b0;
        tick();                                   // edge k3
        startN = 1'b1;
        for (int e = 1; e <= 50; e++) begin
            tick();
            if (e == 49) begin
                check("to_not_yet", pd1, 0);
                check("to_count49", cc1, 49);
            end
        end
        check("to_done", pd1, 1);
        check("to_flag", to1, 1);
        check("to_count", cc1, 50);
        check("to_ready", rdy1, 1);
        check("sat_count", ccs, 4'hf);
        check("sat_running", pds, 0);
        check("sat_no_timeout", tos, 0);
        check("big_to_running", pd4, 0);
        done4  = 4'hf;
        done_s = 1'b1;
        tick();
        done4 = 4'h0;
        check("big_to_done", pd4, 1);
        check("big_to_count", cc4, 51);
        check("big_to_flag", to4, 0);
        check("sat_final", ccs, 4'hf);
        check("sat_done", pds, 1);

        // Phase 4: done on exactly the 50th run cycle beats the timeout
        done4  = 4'hf;
        startN = 1'b0;
        tick();                                   // edge k4
        startN = 1'b1;
        for (int e = 1; e <= 49; e++) tick();
        check("edge_not_yet", pd1, 0);
        done1 = 1'b1;
        tick();                                   // edge k4+50
        done1 = 1'b0;
        done4 = 4'h0;
        check("edge_done", pd1, 1);
        check("edge_count", cc1, 50);
        check("edge_timeout", to1, 0);

        // Phase 5: reset in the middle of RUN
        startN = 1'b0;
        tick();                                   // edge k5
        startN = 1'b1;
        repeat (5) tick();
        check("mid_count", cc1, 5);
        rstN = 1'b0;
        #1;
        check("mid_rst_ready", rdy1, 1);
        check("mid_rst_done", pd1, 0);
        check("mid_rst_count", cc1, 0);
        check("mid_rst_timeout", to1, 0);
        check("mid_rst_count4", cc4, 0);
        tick();
        rstN = 1'b1;
        tick();

        // Phase 6: reset during START suppresses the pulse, then a clean first run
        startN = 1'b0;
        tick();                                   // edge k6
        check("k6_start", cs1, 1);
        rstN = 1'b0;
        #1;
        check("start_rst_pulse", cs1, 0);
        check("start_rst_pulse4", cs4, 0);
        check("start_rst_ready", rdy1, 1);
        startN = 1'b1;
        tick();
        rstN = 1'b1;
        tick();
        check("post_rst_no_pulse", cs1, 0);
        startN = 1'b0;
        tick();                                   // edge k7
        startN = 1'b1;
        check("k7_start", cs1, 1);
        check("k7_count", cc1, 0);
        tick();
        check("k7_pulse_end", cs1, 0);
        check("k7_count1", cc1, 1);
        tick();
        done1 = 1'b1;
        tick();                                   // edge k7+3
        done1 = 1'b0;
        check("k7_done", pd1, 1);
        check("k7_count3", cc1, 3);
        check("k7_timeout", to1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
